// File: rtl/divider_if.sv
// divider_if: operand/result bundle for the sequential divider.
// WIDTH is the divisor/remainder width; dividend and quotient are 2*WIDTH.
interface divider_if #(
  parameter int WIDTH = 32
);
  // Handshake: a request is taken on any rising clk edge where start=1 and busy=0.
  // ain/bin are captured on that edge only. done pulses for one cycle when
  // quot/rem/dbz are updated, and those hold until the next done.
  logic                 start;
  logic [2*WIDTH-1:0]   ain;
  logic [WIDTH-1:0]     bin;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   quot;
  logic [WIDTH-1:0]     rem;
  logic                 dbz;

  modport master (
    output start, ain, bin,
    input  busy, done, quot, rem, dbz
  );

  modport slave (
    input  start, ain, bin,
    output busy, done, quot, rem, dbz
  );
endinterface

// File: rtl/divider.sv
// divider: unsigned restoring divider, one quotient bit per cycle (2*WIDTH iterations).
// Optional DIVIDER_DBZ_EN: a zero divisor skips the iterations and raises dbz.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  divider_if.slave    bus,
  output logic [1:0]  o_dbg_state
);

  localparam int CW = $clog2(2 * WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_zero;
  logic [2*WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]     r_dvs;
  logic [WIDTH:0]       r_part;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]     r_rem;

  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_sub;
  logic                 w_ge;
  logic                 w_accept;

  // The dividend register doubles as the quotient: MSB shifts out, quotient bit shifts in.
  // A set r_part[WIDTH] means the true shifted partial already exceeds any divisor.
  assign w_shift  = {r_part[WIDTH-1:0], r_dvd[2*WIDTH-1]};
  assign w_sub    = w_shift - {1'b0, r_dvs};
  assign w_ge     = r_part[WIDTH] | (w_shift >= {1'b0, r_dvs});
  assign w_accept = bus.start & ~r_busy;

`ifdef DIVIDER_DBZ_EN
  logic r_dbz;
  assign bus.dbz = r_dbz;
`else
  assign bus.dbz = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_zero  <= 1'b0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_part  <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
`ifdef DIVIDER_DBZ_EN
      r_dbz   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
        end
        S_RUN: begin
          if (!r_zero) begin
            r_part <= w_ge ? w_sub : w_shift;
            r_dvd  <= {r_dvd[2*WIDTH-2:0], w_ge};
          end
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= S_FIN;
            r_busy  <= 1'b0;
          end
        end
        S_FIN: begin
          r_quot  <= r_dvd;
          r_rem   <= r_part[WIDTH-1:0];
`ifdef DIVIDER_DBZ_EN
          r_dbz   <= r_zero;
`endif
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Acceptance overrides the case above so FIN can chain straight into the next run.
      if (w_accept) begin
        r_state <= S_RUN;
        r_busy  <= 1'b1;
        r_dvd   <= bus.ain;
        r_dvs   <= bus.bin;
        r_part  <= '0;
        r_cnt   <= CW'(2 * WIDTH);
        r_zero  <= 1'b0;
`ifdef DIVIDER_DBZ_EN
        if (bus.bin == '0) begin
          r_zero <= 1'b1;
          r_cnt  <= CW'(1);
          r_dvd  <= '1;
          r_part <= {1'b0, bus.ain[WIDTH-1:0]};
        end
`endif
      end
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.quot    = r_quot;
  assign bus.rem     = r_rem;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_divider.sv
// tb_divider: directed stimulus with a result scoreboard for the sequential divider.
module tb_divider;

  localparam int WIDTH = 32;
  localparam int RW    = 3 * WIDTH + 1;
`ifdef DIVIDER_DBZ_EN
  localparam bit DBZ = 1'b1;
`else
  localparam bit DBZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  divider_if #(.WIDTH(WIDTH)) bus ();

  divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [RW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            n_asserts = 0;
  int            n_fail    = 0;
  int            n_done    = 0;
  int            n_pushed  = 0;
  logic          prev_done = 1'b0;

  function automatic logic [RW-1:0] model(input logic [2*WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] ext;
    ext = {{WIDTH{1'b0}}, b};
    if (b == '0) return {{2*WIDTH{1'b1}}, a[WIDTH-1:0], DBZ};
    return {a / ext, WIDTH'(a % ext), 1'b0};
  endfunction

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // driver: present operands, push the expectation, step past the accepting edge
  task automatic start_op(input logic [2*WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit hold);
    int c;
    c         = cyc;
    bus.ain   = a;
    bus.bin   = b;
    bus.start = 1'b1;
    exp_q.push_back(model(a, b));
    exp_cyc_q.push_back(c + 1 + ((DBZ && b == '0) ? 2 : 2 * WIDTH + 1));
    n_pushed++;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check(tag, exp_q.size(), 0);
    if (exp_q.size() != 0) begin
      n_pushed -= exp_q.size();
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  // monitor: every done must match the oldest expectation, on the predicted cycle
  always @(negedge clk) begin
    logic [RW-1:0] e;
    int            c;
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (bus.done) begin
        n_done++;
        check("done_single_cycle", prev_done, 1'b0);
        check("done_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("result", {bus.quot, bus.rem, bus.dbz}, e);
          check("latency", cyc, c);
        end
      end
      prev_done = bus.done;
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.ain   = '0;
    bus.bin   = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_quot", bus.quot, 0);
    check("rst_rem",  bus.rem,  0);
    check("rst_dbz",  bus.dbz,  1'b0);
    check("rst_state", dbg_state, 2'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 100 / 7 with cycle-accurate busy/done probes
    start_op(64'd100, 32'd7, 1'b0);
    check("busy_after_accept", bus.busy, 1'b1);
    check("done_after_accept", bus.done, 1'b0);
    repeat (2 * WIDTH - 1) @(posedge clk);
    #1;
    check("busy_last_iter", bus.busy, 1'b1);
    @(posedge clk);
    #1;
    check("busy_in_fin", bus.busy, 1'b0);
    check("done_in_fin", bus.done, 1'b0);
    @(posedge clk);
    #1;
    check("done_pulse", bus.done, 1'b1);
    check("busy_with_done", bus.busy, 1'b0);
    check("quot_100_7", bus.quot, 64'd14);
    check("rem_100_7", bus.rem, 32'd2);
    @(posedge clk);
    #1;
    check("done_cleared", bus.done, 1'b0);
    wait_drain("drain_100_7", 10);

    // undo of the max-operand multiplier product, and a quotient wider than WIDTH
    start_op(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 1'b0);
    wait_drain("drain_maxprod", 100);
    start_op(64'h0000_0001_0000_0000, 32'd1, 1'b0);
    wait_drain("drain_wide_quot", 100);

    // divide by zero
    start_op(64'd310, 32'd0, 1'b0);
    wait_drain("drain_dbz", 100);

    // ignored mid-run request, then reset mid-run
    start_op(64'd100, 32'd7, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    bus.ain   = 64'd50;
    bus.bin   = 32'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_ignore", bus.busy, 1'b1);
    check("quot_held", bus.quot, {2*WIDTH{1'b1}});
    check("rem_held", bus.rem, 32'd310);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    n_pushed -= exp_q.size();
    exp_q.delete();
    exp_cyc_q.delete();
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_quot", bus.quot, 0);
    check("midrst_rem",  bus.rem,  0);
    check("midrst_dbz",  bus.dbz,  1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("postrst_state", dbg_state, 2'd0);
    start_op(64'd50, 32'd3, 1'b0);
    wait_drain("drain_50_3", 100);
    check("quot_50_3", bus.quot, 64'd16);
    check("rem_50_3", bus.rem, 32'd2);

    // back-to-back with start held high
    for (int i = 0; i <= 30; i++) begin
      start_op(64'(10 * i * (i + 1)), 32'(i + 1), 1'b1);
      repeat (2 * WIDTH) @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    wait_drain("drain_b2b", 200);

    check("done_count", n_done, n_pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
